// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port CPU register file with a per-register busy scoreboard.
//   Read side serves decode, write side serves writeback.
//
//   Parameters
//     RF_ADDR_LEN  register address width (depth = 2**RF_ADDR_LEN)
//     RF_DATA_LEN  register data width
//     NUM_RD       number of read ports (1..4)
//     NUM_WR       number of write ports (1..2); the higher index wins on an address clash
//     BYPASS       1: reads and busy see this cycle's writeback; 0: stored state only
//     READ_REG     1: read data/busy registered (1-cycle latency); 0: combinational
//     ZERO_REG     1: x0 reads 0, is never written and never busy
//
//   Ports
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     rs_addr        read addresses, port k at [k*RF_ADDR_LEN +: RF_ADDR_LEN]
//     rs_data        read data, packed like rs_addr
//     rs_busy        scoreboard bit of each read address
//     w_en           per-port write enables
//     rd_addr        write addresses, packed per port
//     rd_write_data  write data, packed per port
//     sb_set_en      mark sb_set_addr busy (instruction issued)
//     sb_set_addr    destination register being issued
module register_file_mp #(
    parameter int RF_ADDR_LEN = 5,
    parameter int RF_DATA_LEN = 32,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 1,
    parameter int BYPASS      = 1,
    parameter int READ_REG    = 0,
    parameter int ZERO_REG    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*RF_ADDR_LEN-1:0]   rs_addr,
    output logic [NUM_RD*RF_DATA_LEN-1:0]   rs_data,
    output logic [NUM_RD-1:0]               rs_busy,
    input  logic [NUM_WR-1:0]               w_en,
    input  logic [NUM_WR*RF_ADDR_LEN-1:0]   rd_addr,
    input  logic [NUM_WR*RF_DATA_LEN-1:0]   rd_write_data,
    input  logic                            sb_set_en,
    input  logic [RF_ADDR_LEN-1:0]          sb_set_addr
);

    localparam int DEPTH = 1 << RF_ADDR_LEN;

    logic [DEPTH-1:0][RF_DATA_LEN-1:0] rf_q, rf_d;
    logic [DEPTH-1:0]                  busy_q, busy_d;
    logic [DEPTH-1:0]                  wb_hit;   // registers written back this cycle
    logic [DEPTH-1:0]                  busy_wb;  // busy bits after this cycle's clears

    logic [NUM_RD-1:0][RF_DATA_LEN-1:0] rs_data_d;
    logic [NUM_RD-1:0]                  rs_busy_d;

    function automatic logic is_zero(input logic [RF_ADDR_LEN-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Next register state. Ports are walked in ascending order so a
    // higher-index write to the same address overrides a lower one.
    // rf_d doubles as the bypass source: it already holds the winning data.
    always_comb begin
        rf_d   = rf_q;
        wb_hit = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (w_en[j]) begin
                wb_hit[rd_addr[j*RF_ADDR_LEN +: RF_ADDR_LEN]] = 1'b1;
                if (!is_zero(rd_addr[j*RF_ADDR_LEN +: RF_ADDR_LEN]))
                    rf_d[rd_addr[j*RF_ADDR_LEN +: RF_ADDR_LEN]] =
                        rd_write_data[j*RF_DATA_LEN +: RF_DATA_LEN];
            end
        end
        busy_wb = busy_q & ~wb_hit;
        busy_d  = busy_wb;
        // Set is applied after clear: a newly issued producer outranks the
        // writeback of an older one to the same register.
        if (sb_set_en && !is_zero(sb_set_addr))
            busy_d[sb_set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q   <= '0;
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    // Per-port read selection. With BYPASS the busy bit excludes this
    // cycle's set, so an issuing instruction does not see its own mark.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [RF_ADDR_LEN-1:0] rd_a;
        assign rd_a = rs_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN];
        assign rs_data_d[k] = is_zero(rd_a) ? '0 :
                              (BYPASS != 0) ? rf_d[rd_a] : rf_q[rd_a];
        assign rs_busy_d[k] = is_zero(rd_a) ? 1'b0 :
                              (BYPASS != 0) ? busy_wb[rd_a] : busy_q[rd_a];
    end

    if (READ_REG != 0) begin : g_rreg
        logic [NUM_RD-1:0][RF_DATA_LEN-1:0] rs_data_q;
        logic [NUM_RD-1:0]                  rs_busy_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rs_data_q <= '0;
                rs_busy_q <= '0;
            end else begin
                rs_data_q <= rs_data_d;
                rs_busy_q <= rs_busy_d;
            end
        end

        assign rs_data = rs_data_q;
        assign rs_busy = rs_busy_q;
    end else begin : g_rcomb
        assign rs_data = rs_data_d;
        assign rs_busy = rs_busy_d;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp. Three instances share one stimulus:
//   dut_a  BYPASS=1 READ_REG=0
//   dut_b  BYPASS=0 READ_REG=0
//   dut_c  BYPASS=1 READ_REG=1
// The driver changes inputs 1 time unit after each rising edge and queues the
// hand-computed outputs expected for that cycle; the monitor compares them on
// the falling edge of the same cycle.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rs_addr = '0;
    logic [1:0]  w_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_write_data = '0;
    logic        sb_set_en = 1'b0;
    logic [4:0]  sb_set_addr = '0;

    logic [63:0] a_data, b_data, c_data;
    logic [1:0]  a_busy, b_busy, c_busy;

    always #5 clk = ~clk;

    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1), .READ_REG(0)) dut_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(a_data), .rs_busy(a_busy),
        .w_en(w_en), .rd_addr(rd_addr), .rd_write_data(rd_write_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));

    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(0), .READ_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(b_data), .rs_busy(b_busy),
        .w_en(w_en), .rd_addr(rd_addr), .rd_write_data(rd_write_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));

    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1), .READ_REG(1)) dut_c (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(c_data), .rs_busy(c_busy),
        .w_en(w_en), .rd_addr(rd_addr), .rd_write_data(rd_write_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr));

    typedef struct {
        int          cyc;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    exp_t e;
    logic [31:0] act_d;
    logic        act_b;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin act_d = a_data[e.port*32 +: 32]; act_b = a_busy[e.port]; end
                1:       begin act_d = b_data[e.port*32 +: 32]; act_b = b_busy[e.port]; end
                default: begin act_d = c_data[e.port*32 +: 32]; act_b = c_busy[e.port]; end
            endcase
            n_checks++;
            if (act_d === e.data && act_b === e.busy)
                n_pass++;
            else
                $display("FAIL %s dut%0d port%0d cyc%0d: data=%h busy=%b, expected data=%h busy=%b",
                         e.name, e.dut, e.port, cyc, act_d, act_b, e.data, e.busy);
        end
    end

    // Advance to just after the next rising edge and drive this cycle's inputs.
    task automatic drive(input logic [4:0] p0, input logic [4:0] p1, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic se, input logic [4:0] sa);
        @(posedge clk);
        #1;
        rs_addr       = {p1, p0};
        w_en          = we;
        rd_addr       = {wa1, wa0};
        rd_write_data = {wd1, wd0};
        sb_set_en     = se;
        sb_set_addr   = sa;
    endtask

    task automatic idle(input logic [4:0] p0, input logic [4:0] p1);
        drive(p0, p1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    // Queue expected (data, busy) of one port on all three instances for this cycle.
    task automatic chk(input string nm, input int p,
                       input logic [31:0] da, input logic ba,
                       input logic [31:0] db, input logic bb,
                       input logic [31:0] dc, input logic bc);
        sb.push_back('{cyc, 0, p, da, ba, nm});
        sb.push_back('{cyc, 1, p, db, bb, nm});
        sb.push_back('{cyc, 2, p, dc, bc, nm});
    endtask

    initial begin
        // Reset held through the first cycle
        idle(5'd0, 5'd0);
        chk("reset_p0", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_p1", 1, 0, 0, 0, 0, 0, 0);

        // Every address on both ports reads 0 / not busy after reset
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            if (i == 0) rst = 1'b0;
            chk("sweep_p0", 0, 0, 0, 0, 0, 0, 0);
            chk("sweep_p1", 1, 0, 0, 0, 0, 0, 0);
        end

        // x5 = DEADBEEF: bypass visible in the write cycle only on dut_a
        drive(5'd5, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("wr_x5_same", 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("wr_x5_same_p1", 1, 0, 0, 0, 0, 0, 0);
        idle(5'd5, 5'd0);
        chk("wr_x5_next", 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);

        // Both ports write x7: port 1 wins
        drive(5'd7, 5'd5, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
        chk("dual_wr_same", 0, 32'h22, 0, 0, 0, 32'hDEADBEEF, 0);
        chk("dual_wr_p1", 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);

        // Write all-ones to x0: dropped, even through bypass
        drive(5'd7, 5'd0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("dual_wr_next", 0, 32'h22, 0, 32'h22, 0, 32'h22, 0);
        chk("x0_wr_same", 1, 0, 0, 0, 0, 32'hDEADBEEF, 0);
        idle(5'd0, 5'd7);
        chk("x0_wr_next", 0, 0, 0, 0, 0, 32'h22, 0);
        chk("x7_p1", 1, 32'h22, 0, 32'h22, 0, 0, 0);

        // Scoreboard on x9
        drive(5'd9, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
        chk("sb_set_same", 0, 0, 0, 0, 0, 0, 0);
        idle(5'd9, 5'd7);
        chk("sb_set_next", 0, 0, 1, 0, 1, 0, 0);
        drive(5'd9, 5'd7, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9);
        chk("sb_setclr_same", 0, 32'h99, 0, 0, 1, 0, 1);
        idle(5'd9, 5'd7);
        chk("sb_setclr_next", 0, 32'h99, 1, 32'h99, 1, 32'h99, 0);
        drive(5'd9, 5'd7, 2'b01, 5'd9, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("sb_clr_same", 0, 32'h1234, 0, 32'h99, 1, 32'h99, 1);
        idle(5'd9, 5'd7);
        chk("sb_clr_next", 0, 32'h1234, 0, 32'h1234, 0, 32'h1234, 0);
        chk("x7_hold", 1, 32'h22, 0, 32'h22, 0, 32'h22, 0);

        // Set on x0 never makes it busy
        drive(5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0);
        chk("x0_set_same", 1, 0, 0, 0, 0, 32'h22, 0);
        idle(5'd9, 5'd0);
        chk("x0_set_next", 1, 0, 0, 0, 0, 0, 0);
        chk("x9_hold", 0, 32'h1234, 0, 32'h1234, 0, 32'h1234, 0);

        // Registered-read latency: x3=A, x4=B, then swap addresses
        drive(5'd3, 5'd4, 2'b11, 5'd3, 32'hA, 5'd4, 32'hB, 1'b0, 5'd0);
        chk("rr_wr_p0", 0, 32'hA, 0, 0, 0, 32'h1234, 0);
        chk("rr_wr_p1", 1, 32'hB, 0, 0, 0, 0, 0);
        idle(5'd3, 5'd4);
        chk("rr_hold_p0", 0, 32'hA, 0, 32'hA, 0, 32'hA, 0);
        chk("rr_hold_p1", 1, 32'hB, 0, 32'hB, 0, 32'hB, 0);
        idle(5'd4, 5'd3);
        chk("rr_swap_p0", 0, 32'hB, 0, 32'hB, 0, 32'hA, 0);
        chk("rr_swap_p1", 1, 32'hA, 0, 32'hA, 0, 32'hB, 0);
        idle(5'd4, 5'd3);
        chk("rr_late_p0", 0, 32'hB, 0, 32'hB, 0, 32'hB, 0);
        chk("rr_late_p1", 1, 32'hA, 0, 32'hA, 0, 32'hA, 0);

        // Burst, then reset between clock edges
        drive(5'd12, 5'd13, 2'b01, 5'd12, 32'h55, 5'd0, 32'h0, 1'b1, 5'd13);
        chk("burst1_p0", 0, 32'h55, 0, 0, 0, 32'hB, 0);
        chk("burst1_p1", 1, 0, 0, 0, 0, 32'hA, 0);
        drive(5'd12, 5'd13, 2'b01, 5'd12, 32'h66, 5'd0, 32'h0, 1'b1, 5'd14);
        chk("burst2_p0", 0, 32'h66, 0, 32'h55, 0, 32'h55, 0);
        chk("burst2_p1", 1, 0, 1, 0, 1, 0, 0);
        idle(5'd12, 5'd13);
        rst = 1'b1;
        chk("async_rst_p0", 0, 0, 0, 0, 0, 0, 0);
        chk("async_rst_p1", 1, 0, 0, 0, 0, 0, 0);
        idle(5'd12, 5'd14);
        rst = 1'b0;
        chk("post_rst_p0", 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_p1", 1, 0, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
